// File: rtl/score_keeper.sv
// Two-player score/HP keeper with IDLE/PLAY/OVER game-phase FSM and BCD scores.
// Optional SCORE_INVULN_EN adds per-player post-damage invulnerability timed in frames.
module score_keeper #(
    parameter int MAX_HP        = 4,
    parameter int INVULN_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pts_p1,
    input  logic       pts_p2,
    input  logic [3:0] pts_val,
    input  logic       dmg_p1,
    input  logic       dmg_p2,
    output logic [3:0] p1_score0,
    output logic [3:0] p1_score1,
    output logic [3:0] p1_score2,
    output logic [3:0] p1_score3,
    output logic [3:0] p2_score0,
    output logic [3:0] p2_score1,
    output logic [3:0] p2_score2,
    output logic [3:0] p2_score3,
    output logic [2:0] p1_hp,
    output logic [2:0] p2_hp,
    output logic       playing,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [1:0] dbg_state
);

    localparam logic [2:0] HP_MAX = 3'(MAX_HP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] p1_score, p2_score;
    logic [15:0] p1_score_nxt, p2_score_nxt;
    logic [2:0]  p1_hp_nxt, p2_hp_nxt;
    logic        hit1, hit2;

    // Adds min(v,9) with a full four-digit decimal ripple; overflow pins at 9999.
    function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [3:0] v);
        logic [4:0]  d;
        logic [3:0]  addend;
        logic        c;
        logic [15:0] r;
        c      = 1'b0;
        r      = 16'd0;
        addend = (v > 4'd9) ? 4'd9 : v;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, s[i*4 +: 4]} + {1'b0, addend} + {4'd0, c};
            addend = 4'd0;
            if (d > 5'd9) begin
                r[i*4 +: 4] = 4'(d - 5'd10);
                c = 1'b1;
            end else begin
                r[i*4 +: 4] = d[3:0];
                c = 1'b0;
            end
        end
        return c ? 16'h9999 : r;
    endfunction

`ifdef SCORE_INVULN_EN
    logic [7:0] p1_inv, p2_inv;

    always_ff @(posedge Clk) begin
        if (!Reset_n || start) begin
            p1_inv <= 8'd0;
            p2_inv <= 8'd0;
        end else begin
            if (state == S_PLAY && hit1)
                p1_inv <= 8'(INVULN_FRAMES);
            else if (frame_tick && p1_inv != 8'd0)
                p1_inv <= p1_inv - 8'd1;
            if (state == S_PLAY && hit2)
                p2_inv <= 8'(INVULN_FRAMES);
            else if (frame_tick && p2_inv != 8'd0)
                p2_inv <= p2_inv - 8'd1;
        end
    end
`else
    logic [7:0] unused_cfg;
    assign unused_cfg = 8'(INVULN_FRAMES) ^ {7'd0, frame_tick};
`endif

    always_comb begin
`ifdef SCORE_INVULN_EN
        hit1 = dmg_p1 && (p1_hp != 3'd0) && (p1_inv == 8'd0);
        hit2 = dmg_p2 && (p2_hp != 3'd0) && (p2_inv == 8'd0);
`else
        hit1 = dmg_p1 && (p1_hp != 3'd0);
        hit2 = dmg_p2 && (p2_hp != 3'd0);
`endif
        p1_hp_nxt    = hit1 ? p1_hp - 3'd1 : p1_hp;
        p2_hp_nxt    = hit2 ? p2_hp - 3'd1 : p2_hp;
        p1_score_nxt = pts_p1 ? bcd_add(p1_score, pts_val) : p1_score;
        p2_score_nxt = pts_p2 ? bcd_add(p2_score, pts_val) : p2_score;
    end

    // start outranks everything except reset, in every state.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            p1_score  <= 16'd0;
            p2_score  <= 16'd0;
            p1_hp     <= HP_MAX;
            p2_hp     <= HP_MAX;
            playing   <= 1'b0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else if (start) begin
            state     <= S_PLAY;
            p1_score  <= 16'd0;
            p2_score  <= 16'd0;
            p1_hp     <= HP_MAX;
            p2_hp     <= HP_MAX;
            playing   <= 1'b1;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else if (state == S_PLAY) begin
            p1_score <= p1_score_nxt;
            p2_score <= p2_score_nxt;
            p1_hp    <= p1_hp_nxt;
            p2_hp    <= p2_hp_nxt;
            if (p1_hp_nxt == 3'd0 || p2_hp_nxt == 3'd0) begin
                state     <= S_OVER;
                playing   <= 1'b0;
                game_over <= 1'b1;
                winner    <= {p1_hp_nxt == 3'd0, p2_hp_nxt == 3'd0};
            end
        end
    end

    assign p1_score0 = p1_score[3:0];
    assign p1_score1 = p1_score[7:4];
    assign p1_score2 = p1_score[11:8];
    assign p1_score3 = p1_score[15:12];
    assign p2_score0 = p2_score[3:0];
    assign p2_score1 = p2_score[7:4];
    assign p2_score2 = p2_score[11:8];
    assign p2_score3 = p2_score[15:12];
    assign dbg_state = state;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed steps then random play, checked against an integer game model.
module tb_score_keeper;

    localparam int MAX_HP = 4;
    localparam int INV    = 2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0, start = 1'b0;
    logic       pts_p1 = 1'b0, pts_p2 = 1'b0, dmg_p1 = 1'b0, dmg_p2 = 1'b0;
    logic [3:0] pts_val = 4'd0;
    logic [3:0] p1_score0, p1_score1, p1_score2, p1_score3;
    logic [3:0] p2_score0, p2_score1, p2_score2, p2_score3;
    logic [2:0] p1_hp, p2_hp;
    logic       playing, game_over;
    logic [1:0] winner, dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: phase 0=idle 1=play 2=over, scores as plain integers
    int m_phase, m_win;
    int m_score[2];
    int m_hp[2];
    int m_inv[2];

    always #5 Clk = ~Clk;

    score_keeper #(.MAX_HP(MAX_HP), .INVULN_FRAMES(INV)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
        .pts_p1(pts_p1), .pts_p2(pts_p2), .pts_val(pts_val),
        .dmg_p1(dmg_p1), .dmg_p2(dmg_p2),
        .p1_score0(p1_score0), .p1_score1(p1_score1), .p1_score2(p1_score2), .p1_score3(p1_score3),
        .p2_score0(p2_score0), .p2_score1(p2_score1), .p2_score2(p2_score2), .p2_score3(p2_score3),
        .p1_hp(p1_hp), .p2_hp(p2_hp), .playing(playing), .game_over(game_over),
        .winner(winner), .dbg_state(dbg_state)
    );

    function automatic int digit(input int s, input int k);
        return (s / (10 ** k)) % 10;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        m_score[0] = 0; m_score[1] = 0;
        m_hp[0] = MAX_HP; m_hp[1] = MAX_HP;
        m_inv[0] = 0; m_inv[1] = 0;
        m_win = 0;
    endtask

    task automatic mdl_step(input bit rst_n, input bit st, input bit a1, input bit a2,
                            input int v, input bit d1, input bit d2, input bit tk);
        bit a[2];
        bit d[2];
        bit hit[2];
        a[0] = a1; a[1] = a2; d[0] = d1; d[1] = d2;
        if (!rst_n) begin
            m_phase = 0;
            mdl_clear();
        end else if (st) begin
            m_phase = 1;
            mdl_clear();
        end else begin
            for (int p = 0; p < 2; p++) begin
                hit[p] = 1'b0;
`ifdef SCORE_INVULN_EN
                if (m_phase == 1 && d[p] && m_inv[p] == 0) hit[p] = 1'b1;
`else
                if (m_phase == 1 && d[p]) hit[p] = 1'b1;
`endif
                if (m_phase == 1 && a[p])
                    m_score[p] = (m_score[p] + (v > 9 ? 9 : v) > 9999) ? 9999
                                 : m_score[p] + (v > 9 ? 9 : v);
                if (hit[p] && m_hp[p] > 0) m_hp[p]--;
`ifdef SCORE_INVULN_EN
                if (hit[p]) m_inv[p] = INV;
                else if (tk && m_inv[p] > 0) m_inv[p]--;
`endif
            end
            if (m_phase == 1 && (m_hp[0] == 0 || m_hp[1] == 0)) begin
                m_phase = 2;
                m_win = (m_hp[0] == 0 ? 2 : 0) + (m_hp[1] == 0 ? 1 : 0);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_p1d0"}, 16'(p1_score0), 16'(digit(m_score[0], 0)));
        chk({tag, "_p1d1"}, 16'(p1_score1), 16'(digit(m_score[0], 1)));
        chk({tag, "_p1d2"}, 16'(p1_score2), 16'(digit(m_score[0], 2)));
        chk({tag, "_p1d3"}, 16'(p1_score3), 16'(digit(m_score[0], 3)));
        chk({tag, "_p2d0"}, 16'(p2_score0), 16'(digit(m_score[1], 0)));
        chk({tag, "_p2d1"}, 16'(p2_score1), 16'(digit(m_score[1], 1)));
        chk({tag, "_p2d2"}, 16'(p2_score2), 16'(digit(m_score[1], 2)));
        chk({tag, "_p2d3"}, 16'(p2_score3), 16'(digit(m_score[1], 3)));
        chk({tag, "_p1hp"}, 16'(p1_hp), 16'(m_hp[0]));
        chk({tag, "_p2hp"}, 16'(p2_hp), 16'(m_hp[1]));
        chk({tag, "_playing"}, 16'(playing), 16'(m_phase == 1));
        chk({tag, "_over"}, 16'(game_over), 16'(m_phase == 2));
        chk({tag, "_winner"}, 16'(winner), 16'(m_phase == 2 ? m_win : 0));
    endtask

    // one clock: drive at negedge, update model at posedge, sample 1 ns later
    task automatic step(input bit rst_n, input bit st, input bit a1, input bit a2,
                        input logic [3:0] v, input bit d1, input bit d2, input bit tk,
                        input string tag);
        @(negedge Clk);
        Reset_n = rst_n; start = st; pts_p1 = a1; pts_p2 = a2; pts_val = v;
        dmg_p1 = d1; dmg_p2 = d2; frame_tick = tk;
        @(posedge Clk);
        mdl_step(rst_n, st, a1, a2, int'(v), d1, d2, tk);
        #1;
        check_all(tag);
    endtask

    initial begin
        m_phase = 0;
        mdl_clear();

        // reset, then events in IDLE are ignored
        step(0, 0, 0, 0, 4'd0, 0, 0, 0, "rst");
        step(0, 1, 1, 1, 4'd5, 1, 1, 0, "rst_prio");
        chk("rst_p1hp_const", 16'(p1_hp), 16'd4);
        step(1, 0, 1, 1, 4'd5, 1, 1, 1, "idle_ign");

        // 7+7+7 = 21 for P1
        step(1, 1, 0, 0, 4'd0, 0, 0, 0, "start");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 4'd7, 0, 0, 0, "add7");
        chk("t21_ones", 16'(p1_score0), 16'd1);
        chk("t21_tens", 16'(p1_score1), 16'd2);
        chk("t21_playing", 16'(playing), 16'd1);

        // P2 to 9995, then +9 saturates; P1 from 0 with 15 clamps to 9
        step(1, 1, 0, 0, 4'd0, 0, 0, 0, "restart");
        for (int i = 0; i < 1110; i++) step(1, 0, 0, 1, 4'd9, 0, 0, 0, "pre");
        step(1, 0, 0, 1, 4'd5, 0, 0, 0, "pre5");
        step(1, 0, 0, 1, 4'd9, 0, 0, 0, "sat");
        chk("sat_d3", 16'(p2_score3), 16'd9);
        chk("sat_d0", 16'(p2_score0), 16'd9);
        step(1, 0, 1, 0, 4'd15, 0, 0, 0, "clamp");
        chk("clamp_p1", 16'(p1_score0), 16'd9);
        step(1, 0, 0, 1, 4'd3, 0, 0, 0, "sat_hold");

`ifndef SCORE_INVULN_EN
        // four consecutive hits end the game for P1; events after are frozen
        step(1, 1, 0, 0, 4'd0, 0, 0, 0, "g3");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 4'd2, 1, 0, 0, "dmg");
        chk("dmg_hp0", 16'(p1_hp), 16'd0);
        chk("dmg_win", 16'(winner), 16'd2);
        chk("dmg_over", 16'(game_over), 16'd1);
        step(1, 0, 1, 1, 4'd4, 1, 1, 0, "over_frz");

        // simultaneous last hit gives a draw, then start clears it
        step(1, 1, 0, 0, 4'd0, 0, 0, 0, "g4");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'd0, 1, 1, 0, "both");
        step(1, 0, 0, 0, 4'd0, 1, 1, 0, "draw");
        chk("draw_win", 16'(winner), 16'd3);
        step(1, 1, 1, 1, 4'd8, 1, 1, 0, "draw_rst");
        chk("draw_rst_win", 16'(winner), 16'd0);
        chk("draw_rst_hp", 16'(p2_hp), 16'd4);

        // reset mid-game at score 21 / hp 2
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 4'd7, 0, 0, 0, "mid7");
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 4'd0, 1, 0, 0, "middmg");
        chk("mid_hp2", 16'(p1_hp), 16'd2);
`else
        // invulnerability window of two frames
        step(1, 1, 0, 0, 4'd0, 0, 0, 0, "inv");
        step(1, 0, 0, 0, 4'd0, 1, 0, 0, "inv_hit");
        chk("inv_hp3", 16'(p1_hp), 16'd3);
        step(1, 0, 0, 0, 4'd0, 1, 0, 1, "inv_block");
        chk("inv_block", 16'(p1_hp), 16'd3);
        step(1, 0, 0, 0, 4'd0, 0, 0, 1, "inv_tick2");
        step(1, 0, 0, 0, 4'd0, 1, 0, 0, "inv_hit2");
        chk("inv_hp2", 16'(p1_hp), 16'd2);
`endif
        step(0, 0, 0, 0, 4'd0, 0, 0, 0, "midrst");
        chk("midrst_play", 16'(playing), 16'd0);
        chk("midrst_hp", 16'(p1_hp), 16'd4);
        step(1, 0, 1, 0, 4'd7, 0, 0, 0, "post_rst_pts");
        chk("post_rst_pts", 16'(p1_score0), 16'd0);

        // random play
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
